// File: rtl/npxl_decoder.sv
`default_nettype none
// ============================================================================
// Module      : npxl_decoder
// Description : WS2812 (NeoPixel) serial line decoder. Measures high/low
//               times on the synchronized data line, assembles 24-bit GRB
//               pixels, tracks the pixel position within a frame and flags
//               latch gaps and protocol errors.
// Revision    : 1.0 - initial release
// ============================================================================
module npxl_decoder #(
    parameter int LEDS     = 20,
    parameter int ADDR     = 8,
    parameter int T_THRESH = 30,
    parameter int T_HMIN   = 5,
    parameter int T_HMAX   = 60,
    parameter int T_LATCH  = 2500
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_npxl_data,
    output logic [23:0]     o_pixel,
    output logic [ADDR-1:0] o_index,
    output logic            o_valid,
    output logic            o_frame_done,
    output logic            o_err
);

    localparam int CW = $clog2(T_LATCH + 1);
    localparam int PW = $clog2(LEDS + 1);

    localparam logic [1:0] S_SYNC = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;

    localparam logic [CW-1:0] c_LATCH    = CW'(T_LATCH);
    localparam logic [CW-1:0] c_LATCH_M1 = CW'(T_LATCH - 1);
    localparam logic [CW-1:0] c_HMIN     = CW'(T_HMIN);
    localparam logic [CW-1:0] c_HMAX     = CW'(T_HMAX);
    localparam logic [CW-1:0] c_THRESH   = CW'(T_THRESH);
    localparam logic [PW-1:0] c_LEDS     = PW'(LEDS);

    logic          r_sync1, r_sync2;
    logic [1:0]    r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_bit_cnt;
    logic [PW-1:0] r_pix_cnt;
    logic [22:0]   r_shift;

    logic w_din;
    logic w_latch, w_short, w_long, w_bit_ok, w_bit_val;
    logic w_pix_done, w_overflow;
    logic w_err_set, w_done_set, w_valid_set;

    assign w_din = r_sync2;

    // Two-flop synchronizer for the asynchronous data line
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_npxl_data;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_SYNC;
        else          r_state <= w_next;
    end

    // FSM next-state decode; the line level alone implies the edge per state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_SYNC: if (!w_din && (r_cnt == c_LATCH_M1)) w_next = S_LOW;
            S_LOW:  if (w_din) w_next = S_HIGH;
            S_HIGH: begin
                if (!w_din)                 w_next = (r_cnt < c_HMIN) ? S_SYNC : S_LOW;
                else if (r_cnt == c_HMAX)   w_next = S_SYNC;
            end
            default: w_next = S_SYNC;
        endcase
    end

    // FSM output decode: bit, pixel, gap and error events for this cycle
    always_comb begin
        w_latch     = (r_state == S_LOW)  && !w_din && (r_cnt == c_LATCH_M1);
        w_short     = (r_state == S_HIGH) && !w_din && (r_cnt <  c_HMIN);
        w_long      = (r_state == S_HIGH) &&  w_din && (r_cnt == c_HMAX);
        w_bit_ok    = (r_state == S_HIGH) && !w_din && (r_cnt >= c_HMIN);
        w_bit_val   = (r_cnt >= c_THRESH);
        w_pix_done  = w_bit_ok && (r_bit_cnt == 5'd23);
        w_overflow  = w_pix_done && (r_pix_cnt == c_LEDS);
        w_valid_set = w_pix_done && !w_overflow;
        w_err_set   = w_short || w_long || w_overflow || (w_latch && (r_bit_cnt != 5'd0));
        w_done_set  = w_latch && ((r_pix_cnt != '0) || (r_bit_cnt != 5'd0));
    end

    // Shared timing counter: low run in SYNC/LOW, high run in HIGH; saturates
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_SYNC: begin
                    if (w_din || (w_next == S_LOW)) r_cnt <= '0;
                    else if (r_cnt != c_LATCH)      r_cnt <= r_cnt + 1'b1;
                end
                S_LOW: begin
                    if (w_din)                 r_cnt <= CW'(1);
                    else if (r_cnt != c_LATCH) r_cnt <= r_cnt + 1'b1;
                end
                S_HIGH: begin
                    if (!w_din || w_long)      r_cnt <= '0;
                    else if (r_cnt != c_LATCH) r_cnt <= r_cnt + 1'b1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Bit/pixel assembly, frame position tracking and registered pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt    <= 5'd0;
            r_pix_cnt    <= '0;
            r_shift      <= '0;
            o_pixel      <= '0;
            o_index      <= '0;
            o_valid      <= 1'b0;
            o_err        <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_valid      <= w_valid_set;
            o_err        <= w_err_set;
            o_frame_done <= w_done_set;

            if ((r_state == S_SYNC) && (w_next == S_LOW)) begin
                r_bit_cnt <= 5'd0;
                r_pix_cnt <= '0;
            end else if (w_short || w_long) begin
                r_bit_cnt <= 5'd0;
            end else if (w_latch) begin
                r_bit_cnt <= 5'd0;
                r_pix_cnt <= '0;
            end else if (w_bit_ok) begin
                r_shift <= {r_shift[21:0], w_bit_val};
                if (w_pix_done) begin
                    r_bit_cnt <= 5'd0;
                    // A pixel beyond the frame length is dropped; count stays at LEDS
                    if (!w_overflow) begin
                        o_pixel   <= {r_shift, w_bit_val};
                        o_index   <= ADDR'(r_pix_cnt);
                        r_pix_cnt <= r_pix_cnt + 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_npxl_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_npxl_decoder
// Description : Scoreboard bench for npxl_decoder. Directed line waveforms
//               push expected events; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npxl_decoder;

    typedef struct packed {
        logic        v;
        logic        e;
        logic        d;
        logic [23:0] px;
        logic [7:0]  ix;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic        data;
    logic [23:0] o_pixel;
    logic [7:0]  o_index;
    logic        o_valid, o_frame_done, o_err;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    ev_t exp_q[$];
    int  due_q[$];
    logic [23:0] exp_px = '0;
    logic [7:0]  exp_ix = '0;

    npxl_decoder dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_npxl_data  (data),
        .o_pixel      (o_pixel),
        .o_index      (o_index),
        .o_valid      (o_valid),
        .o_frame_done (o_frame_done),
        .o_err        (o_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: every output event must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && (o_valid || o_err || o_frame_done)) begin
            ev_t ev;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got v=%b e=%b d=%b px=%h ix=%0d, required no event",
                         o_valid, o_err, o_frame_done, o_pixel, o_index);
            end else begin
                ev = exp_q.pop_front();
                if ({o_valid, o_err, o_frame_done, o_pixel, o_index} !== ev) begin
                    errors++;
                    $display("FAIL event: got v=%b e=%b d=%b px=%h ix=%0d, required v=%b e=%b d=%b px=%h ix=%0d",
                             o_valid, o_err, o_frame_done, o_pixel, o_index,
                             ev.v, ev.e, ev.d, ev.px, ev.ix);
                end
            end
            if (o_valid) begin
                int due;
                due = (due_q.size() != 0) ? due_q.pop_front() : -1;
                checks++;
                if (cyc != due) begin
                    errors++;
                    $display("FAIL valid_latency: got cycle %0d, required cycle %0d", cyc, due);
                end
            end
        end
    end

    task automatic push_ev(input logic v, input logic e, input logic d,
                           input logic [23:0] px, input logic [7:0] ix);
        if (v) begin
            exp_px = px;
            exp_ix = ix;
        end
        exp_q.push_back('{v: v, e: e, d: d, px: exp_px, ix: exp_ix});
    endtask

    task automatic set_line(input logic v);
        @(posedge clk);
        #1;
        data = v;
    endtask

    task automatic hold(input logic v, input int n);
        set_line(v);
        repeat (n - 1) @(posedge clk);
    endtask

    // One bit with explicit timing; track_due registers the valid deadline
    task automatic send_bit_t(input int h, input int l, input bit track_due);
        hold(1'b1, h);
        set_line(1'b0);
        if (track_due) due_q.push_back(cyc + 3);
        repeat (l - 1) @(posedge clk);
    endtask

    task automatic send_bits(input logic [23:0] px, input int nbits, input bit exp_v);
        for (int i = 23; i > 23 - nbits; i--) begin
            if (px[i]) send_bit_t(40, 22, exp_v && (i == 0));
            else       send_bit_t(20, 42, exp_v && (i == 0));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({o_pixel, o_index, o_valid, o_frame_done, o_err} !== '0) begin
            errors++;
            $display("FAIL %s: got px=%h ix=%0d v=%b d=%b e=%b, required all zero",
                     tag, o_pixel, o_index, o_valid, o_frame_done, o_err);
        end
    endtask

    task automatic drain_check(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d events still pending, required 0", tag, exp_q.size());
            exp_q.delete();
            due_q.delete();
        end
    endtask

    // Watchdog
    initial begin
        #(95000 * 20);
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] px;
        rst_n = 1'b0;
        data  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;

        // First pixel after initial sync gap, then latch gap
        hold(1'b0, 2600);
        push_ev(1, 0, 0, 24'h000003, 8'd0);
        send_bits(24'h000003, 24, 1);
        push_ev(0, 0, 1, 24'h0, 8'h0);
        hold(1'b0, 2600);
        drain_check("first_pixel_frame");

        // 21 pixels in a frame: 20 valid, 21st overflows, index holds at 19
        for (int p = 0; p < 21; p++) begin
            px = 24'h00000B ^ (24'(p) << 16) ^ (24'(p) << 4);
            if (p < 20) begin
                push_ev(1, 0, 0, px, 8'(p));
                send_bits(px, 24, 1);
            end else begin
                push_ev(0, 1, 0, 24'h0, 8'h0);
                send_bits(px, 24, 0);
            end
        end
        push_ev(0, 0, 1, 24'h0, 8'h0);
        hold(1'b0, 2600);
        drain_check("full_frame");

        // Short glitch -> error; following pixel ignored until resync
        push_ev(0, 1, 0, 24'h0, 8'h0);
        hold(1'b1, 3);
        hold(1'b0, 50);
        send_bits(24'h123456, 24, 0);
        hold(1'b0, 2600);
        push_ev(1, 0, 0, 24'hA5C3E1, 8'd0);
        send_bits(24'hA5C3E1, 24, 1);
        push_ev(0, 0, 1, 24'h0, 8'h0);
        hold(1'b0, 2600);
        drain_check("glitch_resync");

        // High held 61 clocks -> error; then resync
        push_ev(0, 1, 0, 24'h0, 8'h0);
        hold(1'b1, 61);
        hold(1'b0, 2600);
        drain_check("high_too_long");

        // Timing boundaries: 60 high -> 1, 30 -> 1, 29 -> 0, 5 -> 0
        push_ev(1, 0, 0, 24'hC00000, 8'd0);
        send_bit_t(60, 22, 0);
        send_bit_t(30, 22, 0);
        send_bit_t(29, 22, 0);
        for (int i = 20; i >= 0; i--) send_bit_t(5, 22, i == 0);
        drain_check("bit_boundaries");

        // 10 bits then gap -> error and frame_done together
        push_ev(0, 1, 1, 24'h0, 8'h0);
        send_bits(24'hFFFFFF, 10, 0);
        hold(1'b0, 2600);
        drain_check("partial_pixel_gap");

        // Reset after 12 bits clears outputs immediately
        send_bits(24'h5A5A5A, 12, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_pixel");
        exp_px = '0;
        exp_ix = '0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(1'b0, 2600);
        push_ev(1, 0, 0, 24'hFF00AA, 8'd0);
        send_bits(24'hFF00AA, 24, 1);
        push_ev(0, 0, 1, 24'h0, 8'h0);
        hold(1'b0, 2600);
        drain_check("after_reset_pixel");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/npxl_decoder.md
NPXL_DECODER -- requirements
Module: npxl_decoder

Interface
REQ-001 Parameter LEDS, default 20, number of pixels expected per frame.
REQ-002 Parameter ADDR, default 8, width of the pixel index output.
REQ-003 Parameter T_THRESH, default 30, high-time threshold in clocks: at or above this count the bit is 1, below it the bit is 0.
REQ-004 Parameter T_HMIN, default 5, minimum legal high time in clocks.
REQ-005 Parameter T_HMAX, default 60, maximum legal high time in clocks.
REQ-006 Parameter T_LATCH, default 2500, low time in clocks that marks a latch/reset gap (50 us at 50 MHz).
REQ-007 i_clk  input  1  system clock, 50 MHz, rising edge.
REQ-008 i_rst_n  input  1  asynchronous, active-low reset.
REQ-009 i_npxl_data  input  1  serial NeoPixel (WS2812) data line, asynchronous to i_clk.
REQ-010 o_pixel  output  24  last decoded pixel, GRB order, first received bit is the MSB.
REQ-011 o_index  output  ADDR  position of o_pixel within the current frame, 0-based.
REQ-012 o_valid  output  1  one-cycle pulse when o_pixel/o_index are updated.
REQ-013 o_frame_done  output  1  one-cycle pulse on a latch gap that follows received data.
REQ-014 o_err  output  1  one-cycle pulse on a protocol error.

Function
REQ-015 i_npxl_data SHALL pass through a 2-flop synchronizer; all timing is measured on the synchronized signal.
REQ-016 The FSM SHALL have exactly the states SYNC, LOW and HIGH.
REQ-017 SYNC: count consecutive low cycles; any high clears the count; count = T_LATCH -> LOW with the frame cleared.
REQ-018 LOW: count low cycles; a rising edge -> HIGH with the high counter cleared to 1.
REQ-019 HIGH: count high cycles; a falling edge with count < T_HMIN -> o_err, discard the partial pixel, go to SYNC.
REQ-020 HIGH: count reaching T_HMAX+1 while still high -> o_err, discard the partial pixel, go to SYNC.
REQ-021 HIGH, legal falling edge: shift in bit (count >= T_THRESH), increment the bit count, go to LOW with the low counter cleared.
REQ-022 On the 24th bit: o_pixel <= the assembled word, o_index <= the pixel count, o_valid pulses, bit count <= 0, pixel count +1.
REQ-023 o_valid SHALL be high in the third clock cycle after the cycle in which the raw falling edge is first sampled (fixed latency, no jitter).
REQ-024 A pixel completing when the pixel count = LEDS SHALL NOT pulse o_valid; it SHALL pulse o_err; o_pixel/o_index hold; the pixel count saturates at LEDS.
REQ-025 LOW, low count reaching T_LATCH: if the bit count != 0, pulse o_err and discard the partial bits.
REQ-026 LOW, low count reaching T_LATCH: if the pixel count != 0 or the bit count != 0, pulse o_frame_done.
REQ-027 LOW, low count reaching T_LATCH: clear the pixel and bit counts and remain in LOW.
REQ-028 o_err and o_frame_done in the same cycle SHALL both pulse.
REQ-029 Counters SHALL be sized to hold T_LATCH and SHALL saturate, never wrap.
REQ-030 The low time between bits is not checked for a minimum; only T_LATCH is significant.
REQ-031 o_pixel and o_index SHALL hold their values between o_valid pulses.

Reset
REQ-032 While i_rst_n = 0: state = SYNC, all counters = 0, synchronizer flops = 0, o_pixel = 0, o_index = 0, o_valid = 0, o_frame_done = 0, o_err = 0.
REQ-033 Reset mid-pixel or mid-frame SHALL discard all partial data; after release, decoding resumes only after a full T_LATCH low gap.

Verification
REQ-034 Reset, then 2500 clocks low, then pixel 0x000003 (0-bit = 20 high/42 low, 1-bit = 40 high/22 low) -> exactly one o_valid, o_pixel = 0x000003, o_index = 0, 3-cycle latency.
REQ-035 Loopback with npxl_controller (LEDS = 20), send pulse with value 11 -> 20 o_valid pulses with o_index 0..19, then one o_frame_done, o_err never asserts.
REQ-036 After sync, a 3-clock high glitch -> o_err, no o_valid; a following pixel is ignored until 2500 low clocks, then decodes at o_index = 0.
REQ-037 High held 61 clocks -> o_err.
REQ-038 10 bits then 2500 low clocks -> o_err and o_frame_done in the same cycle, no o_valid.
REQ-039 21 pixels in one frame -> 20 o_valid pulses, then o_err on the 21st pixel, o_index stays 19.
REQ-040 i_rst_n low after 12 bits of a pixel -> all outputs 0 immediately; after release, 2500 low clocks, then pixel 0xFF00AA -> o_pixel = 0xFF00AA, o_index = 0.
